// File: rtl/fp_pkg.sv
// Shared types and constants for the pipelined single-precision subtractor.
// Unpacked operands carry hidden bit + 23 fraction bits + 3 guard bits.
package fp_pkg;

  localparam int              EXP_BIAS = 127;
  localparam logic [7:0]      EXP_MAX  = 8'hFF;
  localparam int              GUARD_W  = 3;
  localparam int              ALN_W    = 1 + 23 + GUARD_W;
  // First biased exponent that no longer fits a finite single-precision value.
  localparam logic signed [9:0] EXP_OVF = 10'(2 * EXP_BIAS + 1);

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [26:0] man;
  } fp_unpacked_t;

  typedef struct packed {
    fp_unpacked_t a;
    fp_unpacked_t b;
    logic         exc;
  } s1_pay_t;

  typedef struct packed {
    logic        sign_a;
    logic        sign_b;
    logic [7:0]  exp;
    logic [26:0] man_a;
    logic [26:0] man_b;
    logic        exc;
  } s2_pay_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] mag;
    logic        exc;
  } s3_pay_t;

  // Subnormals and zeros collapse to a signed zero with an all-zero mantissa.
  function automatic fp_unpacked_t fp_unpack(input logic [31:0] w, input logic flip);
    fp_unpacked_t u;
    u.sign = w[31] ^ flip;
    if (w[30:23] == 8'h00) begin
      u.exp = 8'h00;
      u.man = '0;
    end else begin
      u.exp = w[30:23];
      u.man = {1'b1, w[22:0], {GUARD_W{1'b0}}};
    end
    return u;
  endfunction

endpackage

// File: rtl/fp_norm.sv
// Combinational normaliser: carry handling, leading-zero count, left shift,
// exponent adjust and truncation of the guard bits.
module fp_norm
  import fp_pkg::*;
(
  input  logic [7:0]        exp_i,
  input  logic [27:0]       mag_i,
  output logic signed [9:0] exp_o,
  output logic [22:0]       frac_o,
  output logic              zero_o
);

  logic [4:0] lzc;

  always_comb begin
    lzc = 5'd0;
    for (int i = 0; i < ALN_W; i++) begin
      if (mag_i[i]) lzc = 5'(ALN_W - 1 - i);
    end
  end

  // The fraction is bits [25:3] of (mag << lzc); splitting on lzc vs the guard
  // width keeps the shift inside 23 bits without a wider temporary.
  always_comb begin
    zero_o = (mag_i == '0);
    if (mag_i[27]) begin
      exp_o  = $signed({2'b00, exp_i}) + 10'sd1;
      frac_o = mag_i[26:4];
    end else begin
      exp_o = $signed({2'b00, exp_i}) - $signed({5'b00000, lzc});
      if (lzc >= 5'(GUARD_W)) frac_o = 23'(mag_i[25:0] << (lzc - 5'(GUARD_W)));
      else                    frac_o = 23'(mag_i[25:0] >> (5'(GUARD_W) - lzc));
    end
  end

endmodule

// File: rtl/fp_sub_pipe.sv
// Pipelined IEEE-754 single subtractor Out = M1 - M2 with exception flag EX.
// Define FP_SUB_ADD_MODE_EN to add an op port (op=1 subtract, op=0 add).
module fp_sub_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   M1,
  input  logic [EXP_W+MAN_W:0]   M2,
`ifdef FP_SUB_ADD_MODE_EN
  input  logic                   op,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   Out,
  output logic                   EX
);

  // Handshake: a word moves whenever valid and ready are both high at a rising
  // edge. The whole pipe advances together when the output slot is empty or
  // being taken; otherwise every stage, bubbles included, holds its contents.
  logic adv;

  logic        s0_v_q, s1_v_q, s2_v_q, s3_v_q, out_valid_q;
  logic [31:0] s0_a_q, s0_b_q;
  s1_pay_t     s1_d, s1_q;
  s2_pay_t     s2_d, s2_q;
  s3_pay_t     s3_d, s3_q;
  logic [31:0] out_d, out_q;
  logic        ex_d, ex_q;
  logic        sub_flip;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign Out       = out_q;
  assign EX        = ex_q;

`ifdef FP_SUB_ADD_MODE_EN
  logic s0_op_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      s0_op_q <= 1'b0;
    else if (adv && in_valid)     s0_op_q <= op;
  end
  assign sub_flip = s0_op_q;
`else
  assign sub_flip = 1'b1;
`endif

  // S1: unpack, flush subnormals, flag inf/NaN, order by magnitude.
  fp_unpacked_t ua, ub;
  logic         swap;
  always_comb begin
    ua       = fp_unpack(s0_a_q, 1'b0);
    ub       = fp_unpack(s0_b_q, sub_flip);
    swap     = {ub.exp, ub.man} > {ua.exp, ua.man};
    s1_d.a   = swap ? ub : ua;
    s1_d.b   = swap ? ua : ub;
    s1_d.exc = (s0_a_q[30:23] == EXP_MAX) || (s0_b_q[30:23] == EXP_MAX);
  end

  // S2: align the smaller operand; bits shifted out are dropped.
  logic [7:0] exp_diff;
  always_comb begin
    exp_diff    = s1_q.a.exp - s1_q.b.exp;
    s2_d.sign_a = s1_q.a.sign;
    s2_d.sign_b = s1_q.b.sign;
    s2_d.exp    = s1_q.a.exp;
    s2_d.man_a  = s1_q.a.man;
    s2_d.man_b  = (exp_diff >= 8'(ALN_W)) ? '0 : (s1_q.b.man >> exp_diff);
    s2_d.exc    = s1_q.exc;
  end

  // S3: magnitude add or subtract; |A| >= |B| keeps the difference non-negative.
  always_comb begin
    s3_d.sign = s2_q.sign_a;
    s3_d.exp  = s2_q.exp;
    s3_d.exc  = s2_q.exc;
    if (s2_q.sign_a == s2_q.sign_b) s3_d.mag = {1'b0, s2_q.man_a} + {1'b0, s2_q.man_b};
    else                            s3_d.mag = {1'b0, s2_q.man_a} - {1'b0, s2_q.man_b};
  end

  // S4: normalise and pack; every exceptional or flushed case yields +0.
  logic signed [9:0] norm_exp;
  logic [22:0]       norm_frac;
  logic              norm_zero;

  fp_norm u_norm (
    .exp_i  (s3_q.exp),
    .mag_i  (s3_q.mag),
    .exp_o  (norm_exp),
    .frac_o (norm_frac),
    .zero_o (norm_zero)
  );

  always_comb begin
    out_d = 32'h0000_0000;
    ex_d  = 1'b0;
    if (s3_q.exc || (!norm_zero && norm_exp >= EXP_OVF)) ex_d = 1'b1;
    else if (!norm_zero && norm_exp > 10'sd0) out_d = {s3_q.sign, norm_exp[7:0], norm_frac};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_v_q      <= 1'b0;
      s1_v_q      <= 1'b0;
      s2_v_q      <= 1'b0;
      s3_v_q      <= 1'b0;
      out_valid_q <= 1'b0;
      s0_a_q      <= '0;
      s0_b_q      <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      out_q       <= '0;
      ex_q        <= 1'b0;
    end else if (adv) begin
      s0_v_q      <= in_valid;
      if (in_valid) begin
        s0_a_q <= M1;
        s0_b_q <= M2;
      end
      s1_v_q      <= s0_v_q;
      s1_q        <= s1_d;
      s2_v_q      <= s1_v_q;
      s2_q        <= s2_d;
      s3_v_q      <= s2_v_q;
      s3_q        <= s3_d;
      out_valid_q <= s3_v_q;
      if (s3_v_q) begin
        out_q <= out_d;
        ex_q  <= ex_d;
      end
    end
  end

endmodule
